// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - WIDTH-bit sequential ALU with accumulator, flags and start/busy/done handshake
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             use_acc,
    input  logic             wr_acc,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CNTW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_NOT   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_ASR   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

    state_t             state, state_n;
    logic [3:0]         op_q;
    logic               wr_q;
    logic [WIDTH-1:0]   work;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [CNTW-1:0]    cnt;
    logic [CNTW-1:0]    k_eff;

    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_op;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_c;
    logic               sc_v;
    logic               is_shift;
    logic               multi;
    logic               last;

    logic [WIDTH-1:0]   sh_next;
    logic               sh_c;

    logic               fin_valid;
    logic [WIDTH-1:0]   fin_result;
    logic               fin_c;
    logic               fin_v;
    logic               fin_wr;

    assign busy = (state != IDLE);
    assign last = (cnt == CNTW'(1));

    // Single-cycle datapath works directly on the live inputs in the start cycle.
    always_comb begin
        a_sel     = use_acc ? acc : a;
        b_op      = (op == OP_SUB) ? ~b : b;
        sum       = {1'b0, a_sel} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        k_eff     = ({1'b0, b} >= WIDTH_EXT) ? CNTW'(WIDTH) : CNTW'(b);
        is_shift  = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
        multi     = (is_shift && (k_eff != '0)) || (op == OP_MUL);
        sc_result = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_result = sum[WIDTH-1:0];
                sc_c      = sum[WIDTH];
                sc_v      = (a_sel[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);
            end
            OP_NOT:                 sc_result = ~a_sel;
            OP_AND:                 sc_result = a_sel & b;
            OP_OR:                  sc_result = a_sel | b;
            OP_XOR:                 sc_result = a_sel ^ b;
            OP_SHL, OP_SHR, OP_ASR: sc_result = a_sel;
            OP_PASSB:               sc_result = b;
            default:                sc_result = '0;
        endcase
    end

    always_comb begin
        sh_next = {work[WIDTH-2:0], 1'b0};
        sh_c    = work[WIDTH-1];
        case (op_q)
            OP_SHR: begin
                sh_next = {1'b0, work[WIDTH-1:1]};
                sh_c    = work[0];
            end
            OP_ASR: begin
                sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
                sh_c    = work[0];
            end
            default: ;
        endcase
        prod_next = prod + (work[0] ? mcand : '0);
    end

    // Selects which path delivers a completed result this cycle.
    always_comb begin
        fin_valid  = 1'b0;
        fin_result = '0;
        fin_c      = 1'b0;
        fin_v      = 1'b0;
        fin_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !multi) begin
                    fin_valid  = 1'b1;
                    fin_result = sc_result;
                    fin_c      = sc_c;
                    fin_v      = sc_v;
                    fin_wr     = wr_acc && (op <= OP_PASSB);
                end
            end
            SHIFT: begin
                if (last) begin
                    fin_valid  = 1'b1;
                    fin_result = sh_next;
                    fin_c      = sh_c;
                    fin_wr     = wr_q;
                end
            end
            MUL: begin
                if (last) begin
                    fin_valid  = 1'b1;
                    fin_result = prod_next[WIDTH-1:0];
                    fin_c      = |prod_next[2*WIDTH-1:WIDTH];
                    fin_wr     = wr_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        if (clr) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:       if (start && multi) state_n = (op == OP_MUL) ? MUL : SHIFT;
                SHIFT, MUL: if (last) state_n = IDLE;
                default:    state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            op_q   <= '0;
            wr_q   <= 1'b0;
            work   <= '0;
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (clr) begin
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= fin_valid;
            if (fin_valid) begin
                result <= fin_result;
                flag_z <= (fin_result == '0);
                flag_n <= fin_result[WIDTH-1];
                flag_c <= fin_c;
                flag_v <= fin_v;
                if (fin_wr) acc <= fin_result;
            end
            case (state)
                IDLE: begin
                    if (start && multi) begin
                        op_q <= op;
                        wr_q <= wr_acc;
                        prod <= '0;
                        if (op == OP_MUL) begin
                            work  <= b;
                            mcand <= {{WIDTH{1'b0}}, a_sel};
                            cnt   <= CNTW'(WIDTH);
                        end else begin
                            work  <= a_sel;
                            mcand <= '0;
                            cnt   <= k_eff;
                        end
                    end
                end
                SHIFT: begin
                    work <= sh_next;
                    cnt  <= cnt - CNTW'(1);
                end
                MUL: begin
                    prod  <= prod_next;
                    mcand <= {mcand[2*WIDTH-2:0], 1'b0};
                    work  <= {1'b0, work[WIDTH-1:1]};
                    cnt   <= cnt - CNTW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq against an arithmetic reference model
module tb_alu_seq;

    localparam int W = 8;
    localparam longint MASK = (64'sd1 <<< W) - 1;

    logic         hz100 = 1'b0;
    logic         reset, start, cin, use_acc, wr_acc, clr;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, flag_z, flag_n, flag_c, flag_v;
    logic [W-1:0] result, acc;

    int     checks = 0;
    int     errors = 0;
    longint acc_m  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .hz100(hz100), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cin(cin), .use_acc(use_acc), .wr_acc(wr_acc), .clr(clr),
        .busy(busy), .done(done), .result(result), .acc(acc),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 hz100 = ~hz100;

    function automatic longint sx(input longint x);
        return ((x >> (W - 1)) & 1) != 0 ? x - (64'sd1 <<< W) : x;
    endfunction

    function automatic void model(input int opc, input longint av, input longint bv, input int ci,
                                  output longint r, output bit c, output bit v, output int lat);
        longint s, ss, p, sa;
        int     k;
        r = 0; c = 0; v = 0; lat = 0;
        k = (bv > W) ? W : int'(bv);
        case (opc)
            0: begin
                s = av + bv + ci; r = s & MASK; c = ((s >> W) & 1) != 0;
                ss = sx(av) + sx(bv) + ci;
                v = (ss > (MASK >> 1)) || (ss < -((MASK >> 1) + 1));
            end
            1: begin
                s = av + (~bv & MASK) + ci; r = s & MASK; c = ((s >> W) & 1) != 0;
                ss = sx(av) - sx(bv) - 1 + ci;
                v = (ss > (MASK >> 1)) || (ss < -((MASK >> 1) + 1));
            end
            2: r = ~av & MASK;
            3: r = av & bv;
            4: r = av | bv;
            5: r = av ^ bv;
            6: begin r = (av << k) & MASK; c = (k > 0) && (((av >> (W - k)) & 1) != 0); lat = k; end
            7: begin r = av >> k; c = (k > 0) && (((av >> (k - 1)) & 1) != 0); lat = k; end
            8: begin
                sa = sx(av); r = (sa >>> k) & MASK;
                c = (k > 0) && (((sa >>> (k - 1)) & 1) != 0); lat = k;
            end
            9: begin p = av * bv; r = p & MASK; c = (p >> W) != 0; lat = W; end
            10: r = bv;
            default: r = 0;
        endcase
    endfunction

    task automatic run_op(input int opc, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic ua, input logic wa,
                          output logic [W-1:0] r_o, output logic [3:0] f_o, output int busy_cyc,
                          output bit got_done, output logic busy_at_done, output logic done_after);
        @(negedge hz100);
        op = opc[3:0]; a = av; b = bv; cin = ci; use_acc = ua; wr_acc = wa; start = 1'b1;
        @(posedge hz100); #1;
        start = 1'b0;
        busy_cyc = 0; got_done = 0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            if (done) begin
                got_done = 1;
            end else begin
                if (busy) busy_cyc++;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); use_acc = 1'($urandom);
                @(posedge hz100); #1;
            end
        end
        r_o = result; f_o = {flag_z, flag_n, flag_c, flag_v}; busy_at_done = busy;
        @(posedge hz100); #1;
        done_after = done;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 0; op = 0; a = 0; b = 0; cin = 0; use_acc = 0; wr_acc = 0; clr = 0;
        repeat (3) @(posedge hz100);
        #1;
        checks++;
        if ({busy, done, result, acc, flag_z, flag_n, flag_c, flag_v} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h acc=%h flags=%b%b%b%b, expected all 0",
                     busy, done, result, acc, flag_z, flag_n, flag_c, flag_v);
        end
        @(negedge hz100); reset = 1'b1;
    endtask

    typedef struct {
        int         opc;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [7:0] r;
        logic [3:0] f;
        int         bc;
    } vec_t;

    task automatic test_directed;
        vec_t v[7];
        logic [W-1:0] r_o; logic [3:0] f_o; int bc; bit gd; logic bad, da;
        v[0] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101, 0};
        v[1] = '{1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1010, 0};
        v[2] = '{7, 8'h81, 8'h01, 1'b0, 8'h40, 4'b0010, 1};
        v[3] = '{8, 8'h90, 8'h02, 1'b0, 8'hE4, 4'b0100, 2};
        v[4] = '{6, 8'h5A, 8'h00, 1'b0, 8'h5A, 4'b0000, 0};
        v[5] = '{6, 8'hFF, 8'hC8, 1'b0, 8'h00, 4'b1010, 8};
        v[6] = '{9, 8'h10, 8'h11, 1'b0, 8'h10, 4'b0010, 8};
        foreach (v[i]) begin
            run_op(v[i].opc, v[i].av, v[i].bv, v[i].ci, 1'b0, 1'b0, r_o, f_o, bc, gd, bad, da);
            checks++;
            if (!gd || r_o !== v[i].r || f_o !== v[i].f || bc != v[i].bc || bad !== 1'b0 || da !== 1'b0) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d: got done=%0d result=%h flags(ZNCV)=%b busy=%0d busy@done=%b done_next=%b, expected result=%h flags=%b busy=%0d",
                         i, v[i].opc, gd, r_o, f_o, bc, bad, da, v[i].r, v[i].f, v[i].bc);
            end
        end
    endtask

    task automatic test_accumulate;
        logic [W-1:0] r_o; logic [3:0] f_o; int bc; bit gd; logic bad, da;
        run_op(10, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1, r_o, f_o, bc, gd, bad, da);
        checks++;
        if (acc !== 8'h05) begin errors++; $display("FAIL acc_passb: got acc=%h, expected 05", acc); end
        run_op(0, 8'hEE, 8'h03, 1'b0, 1'b1, 1'b1, r_o, f_o, bc, gd, bad, da);
        checks++;
        if (acc !== 8'h08 || r_o !== 8'h08) begin
            errors++; $display("FAIL acc_add: got acc=%h result=%h, expected 08 08", acc, r_o);
        end
        run_op(12, 8'h77, 8'h66, 1'b1, 1'b1, 1'b1, r_o, f_o, bc, gd, bad, da);
        checks++;
        if (acc !== 8'h08 || r_o !== 8'h00 || f_o !== 4'b1000 || !gd || bc != 0) begin
            errors++;
            $display("FAIL acc_undef_op: got acc=%h result=%h flags=%b done=%0d busy=%0d, expected 08 00 1000 1 0",
                     acc, r_o, f_o, gd, bc);
        end
    endtask

    task automatic test_ignore_start;
        int pulses = 0, bc = 0;
        @(negedge hz100);
        op = 4'd9; a = 8'h10; b = 8'h11; use_acc = 0; wr_acc = 0; start = 1'b1;
        @(posedge hz100); #1;
        op = 4'd0; a = 8'h01; b = 8'h01;
        for (int i = 0; i < 14; i++) begin
            if (i == 4) start = 1'b0;
            if (busy) bc++;
            if (done) pulses++;
            @(posedge hz100); #1;
        end
        checks++;
        if (pulses != 1 || bc != 8 || result !== 8'h10 || flag_c !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start: got pulses=%0d busy=%0d result=%h C=%b, expected 1 8 10 1",
                     pulses, bc, result, flag_c);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge hz100);
        op = 4'd0; a = 8'h01; b = 8'h02; cin = 0; use_acc = 0; wr_acc = 0; start = 1'b1;
        @(posedge hz100); #1;
        checks++;
        if (done !== 1'b1 || result !== 8'h03) begin
            errors++; $display("FAIL b2b_first: got done=%b result=%h, expected 1 03", done, result);
        end
        @(negedge hz100);
        op = 4'd5; a = 8'hF0; b = 8'hFF;
        @(posedge hz100); #1;
        checks++;
        if (done !== 1'b1 || result !== 8'h0F || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_second: got done=%b result=%h busy=%b, expected 1 0F 0", done, result, busy);
        end
        @(negedge hz100); start = 1'b0;
        @(posedge hz100); #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_drop: got done=%b, expected 0", done); end
    endtask

    task automatic test_random;
        logic [W-1:0] r_o, av, bv; logic [3:0] f_o, f_exp; int bc, lat, opc; bit gd, c, v; logic bad, da, ua, wa, ci;
        longint r, aeff;
        @(negedge hz100); clr = 1'b1;
        @(negedge hz100); clr = 1'b0; acc_m = 0;
        for (int i = 0; i < 60; i++) begin
            opc = $urandom_range(0, 15);
            av = W'($urandom); bv = W'($urandom);
            if (opc >= 6 && opc <= 8 && $urandom_range(0, 3) != 0) bv = W'($urandom_range(0, 9));
            ua = 1'($urandom); wa = 1'($urandom); ci = 1'($urandom);
            aeff = ua ? acc_m : longint'(av);
            model(opc, aeff, longint'(bv), int'(ci), r, c, v, lat);
            f_exp = {r == 0, ((r >> (W - 1)) & 1) != 0, c, v};
            if (wa && opc <= 10) acc_m = r;
            run_op(opc, av, bv, ci, ua, wa, r_o, f_o, bc, gd, bad, da);
            checks++;
            if (!gd || r_o !== W'(r) || f_o !== f_exp || bc != lat || da !== 1'b0 || acc !== W'(acc_m)) begin
                errors++;
                $display("FAIL random[%0d] op=%0d A=%h b=%h cin=%b: got done=%0d result=%h flags=%b busy=%0d done_next=%b acc=%h, expected result=%h flags=%b busy=%0d acc=%h",
                         i, opc, W'(aeff), bv, ci, gd, r_o, f_o, bc, da, acc, W'(r), f_exp, lat, W'(acc_m));
            end
        end
    endtask

    task automatic test_abort_clr;
        logic [W-1:0] r_o; logic [3:0] f_o; int bc, pulses = 0; bit gd; logic bad, da;
        run_op(10, 8'h00, 8'h33, 1'b0, 1'b0, 1'b1, r_o, f_o, bc, gd, bad, da);
        @(negedge hz100);
        op = 4'd6; a = 8'h01; b = 8'h05; use_acc = 0; wr_acc = 1; start = 1'b1;
        @(posedge hz100); #1; start = 1'b0;
        repeat (2) @(posedge hz100);
        @(negedge hz100); clr = 1'b1;
        @(posedge hz100); #1;
        checks++;
        if ({busy, done, result, acc, flag_z, flag_n, flag_c, flag_v} !== '0) begin
            errors++;
            $display("FAIL abort_clr: got busy=%b done=%b result=%h acc=%h, expected all 0", busy, done, result, acc);
        end
        @(negedge hz100); clr = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge hz100); #1; if (done) pulses++; end
        checks++;
        if (pulses != 0 || acc !== 8'h00) begin
            errors++; $display("FAIL abort_clr_nodone: got pulses=%0d acc=%h, expected 0 00", pulses, acc);
        end
    endtask

    task automatic test_abort_reset;
        logic [W-1:0] r_o; logic [3:0] f_o; int bc, pulses = 0; bit gd; logic bad, da;
        run_op(10, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, r_o, f_o, bc, gd, bad, da);
        @(negedge hz100);
        op = 4'd9; a = 8'h10; b = 8'h11; use_acc = 0; wr_acc = 1; start = 1'b1;
        @(posedge hz100); #1; start = 1'b0;
        repeat (3) @(posedge hz100);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, acc, flag_z, flag_n, flag_c, flag_v} !== '0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b done=%b result=%h acc=%h, expected all 0", busy, done, result, acc);
        end
        @(negedge hz100); reset = 1'b1;
        for (int i = 0; i < 10; i++) begin @(posedge hz100); #1; if (done || busy) pulses++; end
        checks++;
        if (pulses != 0 || result !== 8'h00) begin
            errors++; $display("FAIL abort_reset_idle: got activity=%0d result=%h, expected 0 00", pulses, result);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_accumulate;
        test_ignore_start;
        test_back_to_back;
        test_random;
        test_abort_clr;
        test_abort_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
